// File: rtl/tqv_bus_pkg.sv
// Shared definitions for the TinyQV peripheral-bus initiator: access sizes,
// FSM encoding and the queued command layout.
package tqv_bus_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned CMD_W  = 1 + SIZE_W + ADDR_W + DATA_W;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_NONE = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef struct packed {
    logic              write;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Illegal size or an address not aligned to the access size.
  function automatic logic cmd_illegal(input logic [SIZE_W-1:0] size,
                                       input logic [ADDR_W-1:0] addr);
    return (size == SZ_NONE) ||
           ((size == SZ_HALF) && addr[0]) ||
           ((size == SZ_WORD) && (addr[1:0] != 2'b00));
  endfunction

  function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] size,
                                                  input logic [DATA_W-1:0] d);
    case (size)
      SZ_BYTE: return {24'h0, d[7:0]};
      SZ_HALF: return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/tqvp_bus_cmd_fifo.sv
// Synchronous command FIFO; pointers carry a wrap bit to separate full from empty.
module tqvp_bus_cmd_fifo #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  assign empty_c = (wptr == rptr);
  assign full_c  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout_c  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full_c) wptr <= wptr + PW'(1);
      if (pop && !empty_c) rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full_c) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tqvp_bus_initiator.sv
// Host end of the TinyQV peripheral bus: queues commands, drives one strobed
// access at a time and returns the result on a valid/ready response port.
module tqvp_bus_initiator #(
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [5:0]  per_address,
  output logic [31:0] per_wdata,
  output logic [1:0]  per_data_write_n,
  output logic [1:0]  per_data_read_n,
  input  logic [31:0] per_rdata,
  input  logic        per_data_ready
);

  import tqv_bus_pkg::*;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [1:0]       state, state_d;
  logic             push, pop, full, empty;
  cmd_t             cmd_in, head;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic             timeout_hit;

  logic [5:0]  per_address_d;
  logic [31:0] per_wdata_d, rsp_rdata_d;
  logic [1:0]  write_n_d, read_n_d;
  logic        rsp_valid_d, rsp_err_d;

  assign cmd_in    = '{write: cmd_write, size: cmd_size, addr: cmd_addr, wdata: cmd_wdata};
  assign push      = cmd_valid && !full;
  assign cmd_ready = !full;
  assign busy      = !empty || (state != ST_IDLE);

  tqvp_bus_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .din     (cmd_in),
    .dout_c  (head),
    .full_c  (full),
    .empty_c (empty)
  );

  assign cnt_inc     = cnt + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d       = state;
    pop           = 1'b0;
    cnt_d         = cnt;
    per_address_d = per_address;
    per_wdata_d   = per_wdata;
    write_n_d     = per_data_write_n;
    read_n_d      = per_data_read_n;
    rsp_valid_d   = rsp_valid;
    rsp_err_d     = rsp_err;
    rsp_rdata_d   = rsp_rdata;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (cmd_illegal(head.size, head.addr)) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else if (head.write) begin
            per_address_d = head.addr;
            per_wdata_d   = head.wdata;
            write_n_d     = head.size;
            state_d       = ST_WRITE;
          end else begin
            per_address_d = head.addr;
            per_wdata_d   = '0;
            read_n_d      = head.size;
            cnt_d         = '0;
            state_d       = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        write_n_d   = 2'b11;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_READ: begin
        // The strobe itself remembers the access size while waiting.
        if (per_data_ready) begin
          rsp_rdata_d = size_mask(per_data_read_n, per_rdata);
          rsp_err_d   = 1'b0;
          read_n_d    = 2'b11;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            read_n_d    = 2'b11;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end
      default: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt              <= '0;
      per_address      <= '0;
      per_wdata        <= '0;
      per_data_write_n <= 2'b11;
      per_data_read_n  <= 2'b11;
      rsp_valid        <= 1'b0;
      rsp_err          <= 1'b0;
      rsp_rdata        <= '0;
    end else begin
      cnt              <= cnt_d;
      per_address      <= per_address_d;
      per_wdata        <= per_wdata_d;
      per_data_write_n <= write_n_d;
      per_data_read_n  <= read_n_d;
      rsp_valid        <= rsp_valid_d;
      rsp_err          <= rsp_err_d;
      rsp_rdata        <= rsp_rdata_d;
    end
  end

endmodule

// File: doc/tqvp_bus_initiator.md
Name: tqvp_bus_initiator

Overview:
- Initiator (host) end of the TinyQV peripheral bus. Accepts queued read/write commands on a valid/ready port and drives address, write data, and the data_write_n/data_read_n strobes toward one peripheral.
- Waits for data_ready, then returns size-masked read data or an error on a valid/ready response port.
- Used for bench-independent peripheral bring-up, and as a sequencer feeding sprite/bitmap loads into video peripherals.

Parameters:
- FIFO_DEPTH, 2, command queue entries; power of two, ≥2.
- TIMEOUT_CYCLES, 16, maximum cycles a read strobe is held without data_ready before erroring; 0 disables the timeout.

Ports:
- clk  in  1  project clock (64 MHz nominal)
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command queue not full
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal
- cmd_addr  in  6  peripheral byte address
- cmd_wdata  in  32  write data, low bytes valid per size
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  zero-extended read data; 0 for writes and errors
- rsp_err  out  1  illegal size, misaligned address, or read timeout
- busy  out  1  queue non-empty or FSM not IDLE
- per_address  out  6  to peripheral address
- per_wdata  out  32  to peripheral data_in
- per_data_write_n  out  2  to peripheral data_write_n; 11 = idle
- per_data_read_n  out  2  to peripheral data_read_n; 11 = idle
- per_rdata  in  32  from peripheral data_out
- per_data_ready  in  1  from peripheral data_ready

Behaviour:
- One clock domain: clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - per_data_write_n = per_data_read_n = 11
  - per_address = 0, per_wdata = 0
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0
  - queue empty, so cmd_ready = 1
  - FSM in IDLE
- Asserting reset mid-transaction drops both strobes immediately and discards the queue and any pending response.
- All outputs are registered except cmd_ready (= !full) and busy.
- Queue:
  - Push on cmd_valid && cmd_ready. Pop only in IDLE.
  - No bypass: a command is never issued in the cycle it is pushed.
  - A push and a pop in the same cycle are both honoured. When the queue is full, cmd_ready stays 0 in that cycle.
  - Commands are issued strictly in FIFO order.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE: when the queue is non-empty, pop the head entry, then:
  - If the command is an error (size = 11, a 16-bit access with addr[0] = 1, or a 32-bit access with addr[1:0] ≠ 0): load rsp_err = 1 and rsp_rdata = 0, go to RESP. No strobe is issued.
  - Else if write: load per_address, per_wdata and per_data_write_n = size; go to WRITE.
  - Else (read): load per_address, per_wdata = 0 and per_data_read_n = size; clear the timeout counter; go to READ.
- WRITE: the strobe is valid for exactly one cycle. On the next edge set per_data_write_n = 11, rsp_err = 0, rsp_rdata = 0; go to RESP. data_ready is ignored for writes.
- READ:
  - Each cycle, if per_data_ready = 1: capture per_rdata masked to size (8-bit → {24'h0, d[7:0]}, 16-bit → {16'h0, d[15:0]}, 32-bit → d), set rsp_err = 0, set per_data_read_n = 11, go to RESP.
  - Else increment the counter. When TIMEOUT_CYCLES ≠ 0 and the counter reaches TIMEOUT_CYCLES: set per_data_read_n = 11, rsp_err = 1, rsp_rdata = 0, go to RESP.
  - data_ready in the same cycle as the timeout takes priority over the timeout.
- RESP:
  - Assert rsp_valid and hold rsp_rdata/rsp_err stable until rsp_valid && rsp_ready.
  - On that handshake clear rsp_valid and go to IDLE. The next pop happens no earlier than the following cycle.
- per_address and per_wdata hold their last values between transactions; only the strobes qualify them.
- Latency with a peripheral whose data_ready is always 1: command accepted at edge E0 → strobe visible from E1 to E2 → rsp_valid visible after E2. A write or read occupies 2 cycles plus the response handshake.
- Strobe encodings are never 11 while in WRITE or READ, and never both active in the same cycle.

Decomposition:
- Shared package tqv_bus_pkg:
  - size constants SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_NONE = 2'b11
  - FSM state encoding
  - command-entry field widths (1 + 2 + 6 + 32 = 41 bits)
- One sub-module: tqvp_bus_cmd_fifo, a synchronous FIFO parameterised on width and depth with full/empty flags and asynchronous reset of its pointers.

Test Plan:
- Reset: assert rst_n = 0 mid-read → both strobes read 11 immediately; cmd_ready = 1, rsp_valid = 0, busy = 0.
- 32-bit write, addr 0x20, wdata 0x00000001, rsp_ready = 1 → per_data_write_n = 10 for exactly one cycle with per_address = 0x20; rsp_valid two cycles after accept, rsp_err = 0, rsp_rdata = 0.
- 8-bit read, addr 0x0C, peripheral per_rdata = 0xABCD1234, ready = 1 → per_data_read_n = 00 for one cycle; rsp_rdata = 0x00000034. Repeat as a 16-bit read → rsp_rdata = 0x00001234.
- Slow and absent ready:
  - 32-bit read with ready first high on the 4th strobe cycle → strobe held 4 cycles, rsp_rdata = per_rdata of that cycle.
  - TIMEOUT_CYCLES = 4 with ready never high → strobe drops after 4 cycles, rsp_err = 1, rsp_rdata = 0.
- Illegal commands: 16-bit access at addr 0x05, 32-bit access at addr 0x02, size 11 → each returns rsp_err = 1 with no strobe cycle observed.
- Backpressure, FIFO_DEPTH = 2, rsp_ready = 0: push 4 commands → 3 accepted (1 in flight, 2 queued), 4th waits with cmd_ready = 0. Raise rsp_ready → 4th accepted; responses arrive in push order.
